// File: rtl/unit_lane_renderer_pkg.sv
// Shared colour constants, unit type encodings and the type-to-colour map
// used by the lane renderer and its per-unit comparator.
package unit_lane_renderer_pkg;

  localparam logic [11:0] UNIT1_COLOR   = 12'hF00;
  localparam logic [11:0] UNIT2_COLOR   = 12'h0F0;
  localparam logic [11:0] UNIT3_COLOR   = 12'h00F;
  localparam logic [11:0] SKY_COLOR     = 12'h37B;
  localparam logic [11:0] GROUND_COLOR  = 12'h2D2;
  localparam logic [11:0] OVERLAP_COLOR = 12'hFFF;
  localparam logic [11:0] BLACK         = 12'h000;

  typedef enum logic [1:0] {
    TYPE_EMPTY = 2'd0,
    TYPE_1     = 2'd1,
    TYPE_2     = 2'd2,
    TYPE_3     = 2'd3
  } unitTypeE;

  function automatic logic [11:0] typeColor(input int t);
    case (t)
      int'(TYPE_1): return UNIT1_COLOR;
      int'(TYPE_2): return UNIT2_COLOR;
      int'(TYPE_3): return UNIT3_COLOR;
      default:      return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/unit_lane_renderer_hit_cmp.sv
// Range comparator for one unit sprite: flags whether the current pixel
// lies inside the unit's horizontal span on the lane.
module unit_hit_cmp
  import unit_lane_renderer_pkg::*;
#(
  parameter int LOC_W   = 9,
  parameter int TYPE_W  = 2,
  parameter int H_W     = 10,
  parameter int UNIT_W  = 10,
  parameter int LANE_X0 = 203
) (
  input  logic [LOC_W-1:0]  loc,
  input  logic [TYPE_W-1:0] unitType,
  input  logic [H_W-1:0]    hCount,
  input  logic              inLane,
  output logic              hit
);

  // Two guard bits keep the span end from wrapping for the largest location.
  localparam int CW = H_W + 2;

  logic [CW-1:0] lo;
  logic [CW-1:0] hi;
  logic [CW-1:0] pos;

  assign lo  = CW'(loc) + CW'(LANE_X0);
  assign hi  = lo + CW'(UNIT_W - 1);
  assign pos = CW'(hCount);

  assign hit = inLane && (unitType != '0) && (pos >= lo) && (pos <= hi);

endmodule

// File: rtl/unit_lane_renderer.sv
// Multi-unit lane renderer: tear-free unit snapshot at the commit line and a
// two-stage registered pixel pipeline producing rgb and an overlap flag.
module unit_lane_renderer
  import unit_lane_renderer_pkg::*;
#(
  parameter int NUM_UNITS    = 16,
  parameter int LOC_W        = 9,
  parameter int TYPE_W       = 2,
  parameter int H_W          = 10,
  parameter int UNIT_W       = 10,
  parameter int LANE_X0      = 203,
  parameter int LANE_TOP     = 386,
  parameter int LANE_BOT     = 395,
  parameter int COMMIT_LINE  = 516,
  parameter int OVERLAP_MARK = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bright,
  input  logic [H_W-1:0]                hCount,
  input  logic [H_W-1:0]                vCount,
  input  logic                          gameSCEN,
  input  logic [NUM_UNITS*LOC_W-1:0]    unitLocs,
  input  logic [NUM_UNITS*TYPE_W-1:0]   unitTypes,
  output logic [11:0]                   rgb,
  output logic                          frameCommit,
  output logic                          overlap
);

  logic                        scenPrev;
  logic                        pending;
  logic [NUM_UNITS*LOC_W-1:0]  shadowLocs;
  logic [NUM_UNITS*TYPE_W-1:0] shadowTypes;

  logic scenEdge;
  logic commitPt;
  logic doCommit;

  assign scenEdge = gameSCEN & ~scenPrev;
  assign commitPt = (vCount == H_W'(COMMIT_LINE)) && (hCount == '0);
  assign doCommit = commitPt && (pending || scenEdge);

  // A tick that lands on the commit cycle itself commits without going pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      scenPrev    <= 1'b0;
      pending     <= 1'b0;
      frameCommit <= 1'b0;
      shadowLocs  <= '0;
      shadowTypes <= '0;
    end else begin
      scenPrev    <= gameSCEN;
      frameCommit <= doCommit;
      if (doCommit) begin
        shadowLocs  <= unitLocs;
        shadowTypes <= unitTypes;
        pending     <= 1'b0;
      end else if (scenEdge) begin
        pending <= 1'b1;
      end
    end
  end

  // ---- stage 1: lane test, per-unit hits, lowest-index colour ----
  logic                 inLane;
  logic                 isGround;
  logic [NUM_UNITS-1:0] hit;
  logic [11:0]          firstColor;

  assign inLane   = (vCount >= H_W'(LANE_TOP)) && (vCount <= H_W'(LANE_BOT));
  assign isGround = vCount > H_W'(LANE_BOT);

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : gUnit
    unit_hit_cmp #(
      .LOC_W   (LOC_W),
      .TYPE_W  (TYPE_W),
      .H_W     (H_W),
      .UNIT_W  (UNIT_W),
      .LANE_X0 (LANE_X0)
    ) uHit (
      .loc      (shadowLocs[gi*LOC_W +: LOC_W]),
      .unitType (shadowTypes[gi*TYPE_W +: TYPE_W]),
      .hCount   (hCount),
      .inLane   (inLane),
      .hit      (hit[gi])
    );
  end

  // Scanning from the top index down leaves the lowest-index hit in place.
  always_comb begin
    firstColor = BLACK;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (hit[i]) firstColor = typeColor(int'(shadowTypes[i*TYPE_W +: TYPE_W]));
    end
  end

  logic [NUM_UNITS-1:0] hit_p1;
  logic                 vld_p1;
  logic                 ground_p1;
  logic [11:0]          color_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_p1    <= '0;
      vld_p1    <= 1'b0;
      ground_p1 <= 1'b0;
      color_p1  <= BLACK;
    end else begin
      hit_p1    <= hit;
      vld_p1    <= bright;
      ground_p1 <= isGround;
      color_p1  <= firstColor;
    end
  end

  // ---- stage 2: colour selection and overlap flag ----
  logic        multiHit;
  logic [11:0] rgbNext;
  logic        overlapNext;

  assign multiHit = $countones(hit_p1) >= 2;

  always_comb begin
    rgbNext     = BLACK;
    overlapNext = 1'b0;
    if (vld_p1) begin
      overlapNext = multiHit;
      if (multiHit && (OVERLAP_MARK != 0)) rgbNext = OVERLAP_COLOR;
      else if (|hit_p1)                    rgbNext = color_p1;
      else if (ground_p1)                  rgbNext = GROUND_COLOR;
      else                                 rgbNext = SKY_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb     <= BLACK;
      overlap <= 1'b0;
    end else begin
      rgb     <= rgbNext;
      overlap <= overlapNext;
    end
  end

endmodule

// File: tb/tb_unit_lane_renderer.sv
// Self-checking bench for unit_lane_renderer: directed scenarios plus random
// unit sets checked against a pixel-rule reference model.
module tb_unit_lane_renderer;

  localparam int NU = 16;
  localparam int LW = 9;
  localparam int TW = 2;
  localparam int HW = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              bright;
  logic [HW-1:0]     hCount;
  logic [HW-1:0]     vCount;
  logic              gameSCEN;
  logic [NU*LW-1:0]  unitLocs;
  logic [NU*TW-1:0]  unitTypes;
  logic [11:0]       rgb, rgbB;
  logic              frameCommit, frameCommitB;
  logic              overlap, overlapB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  unit_lane_renderer dut (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
    .gameSCEN(gameSCEN), .unitLocs(unitLocs), .unitTypes(unitTypes),
    .rgb(rgb), .frameCommit(frameCommit), .overlap(overlap)
  );

  unit_lane_renderer #(.OVERLAP_MARK(0)) dutB (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
    .gameSCEN(gameSCEN), .unitLocs(unitLocs), .unitTypes(unitTypes),
    .rgb(rgbB), .frameCommit(frameCommitB), .overlap(overlapB)
  );

  // Reference model: committed unit table plus the spec's pixel rules.
  int          mLoc [NU];
  int          mType[NU];
  bit          mPend, mPrev;
  logic [12:0] eA1, eA2, eB1, eB2;
  logic        eCommit;
  wire         mEdge = gameSCEN && !mPrev;

  function automatic logic [11:0] colorOf(input int t);
    if (t == 1) return 12'hF00;
    if (t == 2) return 12'h0F0;
    if (t == 3) return 12'h00F;
    return 12'h000;
  endfunction

  function automatic logic [12:0] refPixel(input int h, input int v, input bit b, input bit mark);
    int n = 0;
    logic [11:0] first = 12'h000;
    logic [11:0] c;
    if (!b) return 13'h0;
    for (int u = 0; u < NU; u++) begin
      if (mType[u] != 0 && v >= 386 && v <= 395 && h >= mLoc[u] + 203 && h <= mLoc[u] + 212) begin
        if (n == 0) first = colorOf(mType[u]);
        n++;
      end
    end
    if (n >= 2 && mark) c = 12'hFFF;
    else if (n >= 1)    c = first;
    else if (v > 395)   c = 12'h2D2;
    else                c = 12'h37B;
    return {(n >= 2) ? 1'b1 : 1'b0, c};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      eA1 <= '0; eA2 <= '0; eB1 <= '0; eB2 <= '0;
      eCommit <= 1'b0; mPend <= 1'b0; mPrev <= 1'b0;
      for (int u = 0; u < NU; u++) begin
        mLoc[u]  <= 0;
        mType[u] <= 0;
      end
    end else begin
      eA2 <= eA1;
      eB2 <= eB1;
      eA1 <= refPixel(int'(hCount), int'(vCount), bright, 1'b1);
      eB1 <= refPixel(int'(hCount), int'(vCount), bright, 1'b0);
      mPrev <= gameSCEN;
      if (int'(vCount) == 516 && hCount == '0 && (mPend || mEdge)) begin
        for (int u = 0; u < NU; u++) begin
          mLoc[u]  <= int'(unitLocs[u*LW +: LW]);
          mType[u] <= int'(unitTypes[u*TW +: TW]);
        end
        mPend   <= 1'b0;
        eCommit <= 1'b1;
      end else begin
        eCommit <= 1'b0;
        if (mEdge) mPend <= 1'b1;
      end
    end
  end

  typedef struct {
    int h; int v; bit b;
    logic [11:0] c; logic [11:0] cB; bit ov;
  } pix_t;

  task automatic setUnit(input int idx, input int loc, input int typ);
    unitLocs[idx*LW +: LW]  = LW'(loc);
    unitTypes[idx*TW +: TW] = TW'(typ);
  endtask

  task automatic pulseScen();
    bright = 1'b0; hCount = HW'(5); vCount = HW'(390);
    gameSCEN = 1'b1;
    @(negedge clk);
    gameSCEN = 1'b0;
    @(negedge clk);
  endtask

  task automatic commitNow();
    bright = 1'b0; hCount = '0; vCount = HW'(516);
    @(negedge clk);
    hCount = HW'(1);
  endtask

  function automatic pix_t mk(input int h, input int v, input bit b,
                              input logic [11:0] c, input logic [11:0] cB, input bit ov);
    pix_t p;
    p.h = h; p.v = v; p.b = b; p.c = c; p.cB = cB; p.ov = ov;
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b1; bright = 1'b1; hCount = HW'(205); vCount = HW'(390);
    gameSCEN = 1'b0; unitLocs = '0; unitTypes = '0;
    setUnit(0, 0, 1);
    repeat (2) @(negedge clk);
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", rgb); end
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL reset_overlap got=%b want=0", overlap); end
    total++; if (frameCommit !== 1'b0) begin bad++; $display("FAIL reset_commit got=%b want=0", frameCommit); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_first_cycle got=%h want=000", rgb); end
    @(negedge clk);
    total++; if (rgb !== 12'h37B) begin bad++; $display("FAIL reset_no_units got=%h want=37B", rgb); end
  endtask

  task automatic test_commit_basic();
    pix_t q[$];
    pulseScen();
    commitNow();
    total++; if (frameCommit !== 1'b1) begin bad++; $display("FAIL commit_pulse got=%b want=1", frameCommit); end
    @(negedge clk);
    total++; if (frameCommit !== 1'b0) begin bad++; $display("FAIL commit_single got=%b want=0", frameCommit); end
    for (int h = 200; h <= 215; h++)
      q.push_back(mk(h, 390, 1'b1, (h >= 203 && h <= 212) ? 12'hF00 : 12'h37B, 12'h0, 1'b0));
    for (int i = 0; i <= q.size(); i++) begin
      if (i < q.size()) begin hCount = HW'(q[i].h); vCount = HW'(q[i].v); bright = q[i].b; end
      @(negedge clk);
      total++; if ({overlap, rgb} !== eA2) begin bad++; $display("FAIL basic_model got=%h want=%h", {overlap, rgb}, eA2); end
      if (i >= 1) begin
        total++;
        if (rgb !== q[i-1].c) begin bad++; $display("FAIL basic_px h=%0d got=%h want=%h", q[i-1].h, rgb, q[i-1].c); end
      end
    end
  endtask

  task automatic test_no_tearing();
    pix_t q[$];
    setUnit(0, 20, 2);
    bright = 1'b1; hCount = HW'(205); vCount = HW'(390); gameSCEN = 1'b1;
    @(negedge clk);
    gameSCEN = 1'b0;
    for (int h = 200; h <= 215; h++)
      q.push_back(mk(h, 390, 1'b1, (h >= 203 && h <= 212) ? 12'hF00 : 12'h37B, 12'h0, 1'b0));
    for (int i = 0; i <= q.size(); i++) begin
      if (i < q.size()) begin hCount = HW'(q[i].h); vCount = HW'(q[i].v); bright = q[i].b; end
      @(negedge clk);
      if (i >= 1) begin
        total++;
        if (rgb !== q[i-1].c) begin bad++; $display("FAIL tear_old h=%0d got=%h want=%h", q[i-1].h, rgb, q[i-1].c); end
      end
    end
    commitNow();
    total++; if (frameCommit !== 1'b1) begin bad++; $display("FAIL tear_commit got=%b want=1", frameCommit); end
    q.delete();
    for (int h = 200; h <= 235; h++)
      q.push_back(mk(h, 390, 1'b1, (h >= 223 && h <= 232) ? 12'h0F0 : 12'h37B, 12'h0, 1'b0));
    for (int i = 0; i <= q.size(); i++) begin
      if (i < q.size()) begin hCount = HW'(q[i].h); vCount = HW'(q[i].v); bright = q[i].b; end
      @(negedge clk);
      total++; if ({overlap, rgb} !== eA2) begin bad++; $display("FAIL tear_model got=%h want=%h", {overlap, rgb}, eA2); end
      if (i >= 1) begin
        total++;
        if (rgb !== q[i-1].c) begin bad++; $display("FAIL tear_new h=%0d got=%h want=%h", q[i-1].h, rgb, q[i-1].c); end
      end
    end
  endtask

  task automatic test_overlap();
    pix_t q[$];
    logic [11:0] c, cB;
    bit ov;
    unitTypes = '0; unitLocs = '0;
    setUnit(3, 50, 2);
    setUnit(7, 55, 3);
    pulseScen();
    commitNow();
    @(negedge clk);
    // unit 3 spans 253..262, unit 7 spans 258..267
    for (int h = 250; h <= 270; h++) begin
      ov = 1'b0;
      if (h >= 258 && h <= 262)      begin c = 12'hFFF; cB = 12'h0F0; ov = 1'b1; end
      else if (h >= 253 && h <= 257) begin c = 12'h0F0; cB = 12'h0F0; end
      else if (h >= 263 && h <= 267) begin c = 12'h00F; cB = 12'h00F; end
      else                           begin c = 12'h37B; cB = 12'h37B; end
      q.push_back(mk(h, 390, 1'b1, c, cB, ov));
    end
    for (int i = 0; i <= q.size(); i++) begin
      if (i < q.size()) begin hCount = HW'(q[i].h); vCount = HW'(q[i].v); bright = q[i].b; end
      @(negedge clk);
      total++; if ({overlapB, rgbB} !== eB2) begin bad++; $display("FAIL ovl_modelB got=%h want=%h", {overlapB, rgbB}, eB2); end
      if (i >= 1) begin
        total++;
        if (rgb !== q[i-1].c || overlap !== q[i-1].ov) begin
          bad++; $display("FAIL ovl_px h=%0d got=%h/%b want=%h/%b", q[i-1].h, rgb, overlap, q[i-1].c, q[i-1].ov);
        end
        total++;
        if (rgbB !== q[i-1].cB || overlapB !== q[i-1].ov) begin
          bad++; $display("FAIL ovl_nomark h=%0d got=%h/%b want=%h/%b", q[i-1].h, rgbB, overlapB, q[i-1].cB, q[i-1].ov);
        end
      end
    end
  endtask

  task automatic test_bright_background();
    pix_t q[$];
    q.push_back(mk(260, 390, 1'b0, 12'h000, 12'h000, 1'b0));
    q.push_back(mk(260, 390, 1'b1, 12'hFFF, 12'h0F0, 1'b1));
    q.push_back(mk(260, 400, 1'b1, 12'h2D2, 12'h2D2, 1'b0));
    q.push_back(mk(700, 400, 1'b1, 12'h2D2, 12'h2D2, 1'b0));
    q.push_back(mk(260, 100, 1'b1, 12'h37B, 12'h37B, 1'b0));
    q.push_back(mk(260, 395, 1'b1, 12'hFFF, 12'h0F0, 1'b1));
    q.push_back(mk(260, 396, 1'b1, 12'h2D2, 12'h2D2, 1'b0));
    q.push_back(mk(260, 386, 1'b1, 12'hFFF, 12'h0F0, 1'b1));
    q.push_back(mk(260, 385, 1'b1, 12'h37B, 12'h37B, 1'b0));
    q.push_back(mk(255, 390, 1'b0, 12'h000, 12'h000, 1'b0));
    for (int i = 0; i <= q.size(); i++) begin
      if (i < q.size()) begin hCount = HW'(q[i].h); vCount = HW'(q[i].v); bright = q[i].b; end
      @(negedge clk);
      if (i >= 1) begin
        total++;
        if (rgb !== q[i-1].c || overlap !== q[i-1].ov) begin
          bad++; $display("FAIL bg_px h=%0d v=%0d got=%h/%b want=%h/%b", q[i-1].h, q[i-1].v, rgb, overlap, q[i-1].c, q[i-1].ov);
        end
        total++;
        if (rgbB !== q[i-1].cB || overlapB !== q[i-1].ov) begin
          bad++; $display("FAIL bg_nomark h=%0d v=%0d got=%h/%b want=%h/%b", q[i-1].h, q[i-1].v, rgbB, overlapB, q[i-1].cB, q[i-1].ov);
        end
      end
    end
  endtask

  task automatic test_max_loc();
    pix_t q[$];
    unitTypes = '0; unitLocs = '0;
    setUnit(15, 511, 1);
    setUnit(1, 0, 0);
    setUnit(5, 100, 0);
    pulseScen();
    commitNow();
    @(negedge clk);
    for (int h = 710; h <= 727; h++)
      q.push_back(mk(h, 390, 1'b1, (h >= 714 && h <= 723) ? 12'hF00 : 12'h37B, 12'h0, 1'b0));
    for (int h = 0; h <= 12; h++)   q.push_back(mk(h, 390, 1'b1, 12'h37B, 12'h0, 1'b0));
    for (int h = 200; h <= 212; h++) q.push_back(mk(h, 390, 1'b1, 12'h37B, 12'h0, 1'b0));
    for (int h = 301; h <= 306; h++) q.push_back(mk(h, 390, 1'b1, 12'h37B, 12'h0, 1'b0));
    for (int i = 0; i <= q.size(); i++) begin
      if (i < q.size()) begin hCount = HW'(q[i].h); vCount = HW'(q[i].v); bright = q[i].b; end
      @(negedge clk);
      if (i >= 1) begin
        total++;
        if (rgb !== q[i-1].c) begin bad++; $display("FAIL maxloc_px h=%0d got=%h want=%h", q[i-1].h, rgb, q[i-1].c); end
      end
    end
  endtask

  task automatic test_multi_pulse_reset();
    int pulses = 0;
    unitTypes = '0; unitLocs = '0;
    setUnit(0, 10, 1);
    repeat (3) pulseScen();
    setUnit(0, 30, 3);
    commitNow();
    for (int i = 0; i < 4; i++) begin
      if (frameCommit === 1'b1) pulses++;
      @(negedge clk);
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL multi_pulse_count got=%0d want=1", pulses); end
    bright = 1'b1; hCount = HW'(235); vCount = HW'(390);
    repeat (2) @(negedge clk);
    total++; if (rgb !== 12'h00F) begin bad++; $display("FAIL multi_inputs_at_commit got=%h want=00F", rgb); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL midreset_rgb got=%h want=000", rgb); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rgb !== 12'h37B) begin bad++; $display("FAIL midreset_hidden got=%h want=37B", rgb); end
    pulseScen();
    commitNow();
    total++; if (frameCommit !== 1'b1) begin bad++; $display("FAIL midreset_commit got=%b want=1", frameCommit); end
    bright = 1'b1; hCount = HW'(235); vCount = HW'(390);
    repeat (2) @(negedge clk);
    total++; if (rgb !== 12'h00F) begin bad++; $display("FAIL midreset_redraw got=%h want=00F", rgb); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int u = 0; u < NU; u++) setUnit(u, $urandom_range(0, 511), $urandom_range(0, 3));
      pulseScen();
      commitNow();
      total++;
      if (frameCommit !== eCommit || frameCommitB !== eCommit) begin
        bad++; $display("FAIL rnd_commit got=%b/%b want=%b", frameCommit, frameCommitB, eCommit);
      end
      for (int i = 0; i < 120; i++) begin
        hCount = HW'($urandom_range(190, 740));
        vCount = HW'($urandom_range(382, 399));
        bright = ($urandom_range(0, 7) != 0);
        gameSCEN = $urandom_range(0, 3) == 0;
        @(negedge clk);
        total++;
        if ({overlap, rgb} !== eA2 || {overlapB, rgbB} !== eB2) begin
          bad++; $display("FAIL rnd_px got=%h/%h want=%h/%h", {overlap, rgb}, {overlapB, rgbB}, eA2, eB2);
        end
      end
      gameSCEN = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_commit_basic();
    test_no_tearing();
    test_overlap();
    test_bright_background();
    test_max_loc();
    test_multi_pulse_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
